regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Controller in front of the 32x64 register file's single write port.
- Shares that write port between NUM_WB writeback requesters (e.g. ALU, load unit, CSR unit) using round-robin arbitration with valid/ready handshakes.
- Keeps a per-register busy scoreboard so decode can stall on RAW hazards and on WAW issue conflicts.
- Drives the register file's rd / write_data / we inputs directly and combinationally.

Parameters:
- NUM_WB, 3, number of writeback requesters (2..8).
- XLEN, 64, data width.
- REG_AW, 5, register index width (32 registers).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_valid  input  NUM_WB  requester i has a result.
- wb_ready  output  NUM_WB  one-hot grant; transfer on valid & ready.
- wb_rd  input  NUM_WB*REG_AW  destination of requester i, packed with i at LSBs.
- wb_data  input  NUM_WB*XLEN  result of requester i, packed.
- issue_valid  input  1  decode issuing an instruction that writes issue_rd.
- issue_rd  input  REG_AW  destination being issued.
- issue_ready  output  1  issue accepted this cycle.
- chk_rs1  input  REG_AW  decode source 1.
- chk_rs2  input  REG_AW  decode source 2.
- hazard1  output  1  chk_rs1 has a pending write.
- hazard2  output  1  chk_rs2 has a pending write.
- rf_rd  output  REG_AW  to register file rd.
- rf_write_data  output  XLEN  to register file write_data.
- rf_we  output  1  to register file we.
- busy_vec  output  32  scoreboard, for debug and coverage.

Behaviour:
- State:
  - busy[31:0]: bit 0 hardwired 0.
  - rr_ptr: index of the highest-priority requester.
- Reset (rst=1 at posedge):
  - busy cleared and rr_ptr set to 0.
  - While rst is high: wb_ready=0, rf_we=0, issue_ready=0, hazard1/2=0, rf_rd=0, rf_write_data=0.
- Arbitration (combinational, 0-cycle latency):
  - Search wb_valid starting at rr_ptr, wrapping modulo NUM_WB; the first asserted requester g gets wb_ready[g]=1.
  - At most one wb_ready bit is high. If no wb_valid is set, all are 0.
  - wb_ready[i] never depends on wb_ready; it depends only on wb_valid, rr_ptr and rst.
- Write port:
  - rf_we = |wb_ready; rf_rd = wb_rd[g]; rf_write_data = wb_data[g].
  - When rf_we=0, rf_rd and rf_write_data are 0.
  - rd=0 is still granted and forwarded; the register file drops it and busy is unaffected.
- rr_ptr update on a grant to g: rr_ptr <= (g+1) mod NUM_WB. With no grant, rr_ptr holds.
- Requester obligations: hold wb_valid, wb_rd and wb_data stable until ready. The arbiter does not check this.
- Issue:
  - issue_ready = issue_valid & ~busy[issue_rd] & ~rst. This stalls WAW.
  - issue_rd=0 is always accepted and never sets busy.
- Scoreboard update at posedge:
  - busy[issue_rd] is set on issue accept when issue_rd != 0.
  - busy[rf_rd] is cleared on a grant.
  - Same index set and cleared in one cycle: set wins (new producer).
  - A grant to a non-busy register writes normally and leaves busy unchanged.
- Hazards:
  - hazard1 = busy[chk_rs1]; hazard2 = busy[chk_rs2], combinational.
  - A register being written this cycle still reads busy=1. The register file's registered read would return the old value that cycle; busy clears on the same edge, so the next-cycle read returns the new value.
- Reset mid-operation: all pending busy bits are dropped and in-flight requests are not granted during rst. After rst deasserts, requesters restart from rr_ptr=0.

Decomposition:
- Shared package holds:
  - constants REG_AW=5, NUM_REGS=32, XLEN=64;
  - a typedef for the register index;
  - requester ID localparams (WB_ALU=0, WB_LSU=1, WB_CSR=2).
- Sub-module rr_arbiter: parameterized NUM_WB, with ports clk, rst, req, grant and the rr_ptr state. It is reusable for other shared ports.
- Scoreboard and muxing stay in regfile_wb_arbiter.

Test Plan:
- Reset, then idle -> wb_ready=0, rf_we=0, busy_vec=0, hazard1=hazard2=0.
- Issue rd=5; next cycle chk_rs1=5 -> hazard1=1 and issue_valid rd=5 gives issue_ready=0. Then wb_valid[1] with rd=5, data=64'hDEAD_BEEF -> wb_ready=3'b010, rf_we=1, rf_rd=5, rf_write_data=DEAD_BEEF, hazard1 still 1 that cycle. Next cycle: hazard1=0, busy_vec[5]=0.
- All three requesters valid continuously for 6 cycles -> grant sequence 0,1,2,0,1,2.
- Same cycle: issue rd=7 accepted (busy[7]=0) while a grant writes rd=7 -> busy[7]=1 next cycle (set wins).
- Issue rd=0 and writeback rd=0 -> issue_ready=1, grant occurs with rf_we=1, busy_vec stays 0.
- busy[3], busy[9] set and rr_ptr=2, then rst for 1 cycle while wb_valid=3'b111 -> no wb_ready during rst. Afterwards busy_vec=0 and the first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_wb_arbiter_pkg;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int XLEN     = 64;

  typedef logic [REG_AW-1:0] reg_idx_t;

  // Requester IDs on the writeback port
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant in the same cycle as req, no grant during rst.
// The pointer moves past the winner, so a requester left ungranted waits at most NUM_WB-1 grants.
module rr_arbiter #(
  parameter int NUM_WB = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WB-1:0] req,
  output logic [NUM_WB-1:0] grant
);
  localparam int PW = $clog2(NUM_WB);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  always_comb begin
    grant   = '0;
    ptr_nxt = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_WB; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_WB) idx = idx - NUM_WB;
      if (!found && !rst && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = (idx == NUM_WB - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else     rr_ptr <= ptr_nxt;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with busy scoreboard: grant, write and hazards are combinational.
// Requesters hold valid until granted; issue stalls while its destination is still pending.
module regfile_wb_arbiter #(
  parameter int NUM_WB = 3,
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WB-1:0]        wb_valid,
  output logic [NUM_WB-1:0]        wb_ready,
  input  logic [NUM_WB*REG_AW-1:0] wb_rd,
  input  logic [NUM_WB*XLEN-1:0]   wb_data,
  input  logic                     issue_valid,
  input  logic [REG_AW-1:0]        issue_rd,
  output logic                     issue_ready,
  input  logic [REG_AW-1:0]        chk_rs1,
  input  logic [REG_AW-1:0]        chk_rs2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [REG_AW-1:0]        rf_rd,
  output logic [XLEN-1:0]          rf_write_data,
  output logic                     rf_we,
  output logic [31:0]              busy_vec
);
  import regfile_wb_arbiter_pkg::*;

  logic [NUM_WB-1:0]   grant;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arbiter #(.NUM_WB(NUM_WB)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wb_valid),
    .grant (grant)
  );

  // Grant is one-hot, so an AND-OR mux selects the winner and yields 0 when idle.
  always_comb begin
    rf_rd         = '0;
    rf_write_data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (grant[i]) begin
        rf_rd         = rf_rd | wb_rd[i*REG_AW +: REG_AW];
        rf_write_data = rf_write_data | wb_data[i*XLEN +: XLEN];
      end
    end
  end

  assign wb_ready    = grant;
  assign rf_we       = |grant;
  assign issue_ready = issue_valid & ~busy[issue_rd] & ~rst;
  assign hazard1     = busy[chk_rs1] & ~rst;
  assign hazard2     = busy[chk_rs2] & ~rst;
  assign busy_vec    = busy;

  // Clear from the writeback first so a same-cycle issue to that index re-marks it busy.
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_rd] = 1'b0;
    if (issue_ready && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter plus reset corner sequences.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NW-1:0]   wb_valid;
  logic [NW-1:0]   wb_ready;
  logic [NW*5-1:0] wb_rd;
  logic [NW*64-1:0] wb_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      chk_rs1, chk_rs2;
  logic            hazard1, hazard2;
  logic [4:0]      rf_rd;
  logic [63:0]     rf_write_data;
  logic            rf_we;
  logic [31:0]     busy_vec;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] lane [NW];

  regfile_wb_arbiter #(.NUM_WB(NW), .XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_rd(rf_rd), .rf_write_data(rf_write_data), .rf_we(rf_we), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  wbv;
    logic [14:0] rds;
    logic        iv;
    reg_idx_t    ird, rs1, rs2;
    logic [2:0]  rdy;
    logic        ir, h1, h2;
    reg_idx_t    rd;
    logic [31:0] busy;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(logic [2:0] wbv, logic [14:0] rds, logic iv, reg_idx_t ird,
                              reg_idx_t rs1, reg_idx_t rs2, logic [2:0] rdy, logic ir,
                              logic h1, logic h2, reg_idx_t rd, logic [31:0] busy);
    vec_t v;
    v.wbv = wbv; v.rds = rds; v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.rdy = rdy; v.ir = ir; v.h1 = h1; v.h2 = h2; v.rd = rd; v.busy = busy;
    return v;
  endfunction

  function automatic logic [63:0] exp_data(logic [2:0] rdy);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < NW; i++) if (rdy[i]) d = lane[i];
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] wbv, input logic [14:0] rds, input logic iv,
                       input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2);
    wb_valid = wbv; wb_rd = rds; issue_valid = iv; issue_rd = ird;
    chk_rs1 = rs1; chk_rs2 = rs2;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " wb_ready"}, 64'(wb_ready), 64'd0);
    chk({tag, " rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, " issue_ready"}, 64'(issue_ready), 64'd0);
    chk({tag, " hazard1"}, 64'(hazard1), 64'd0);
    chk({tag, " hazard2"}, 64'(hazard2), 64'd0);
    chk({tag, " rf_rd"}, 64'(rf_rd), 64'd0);
    chk({tag, " rf_write_data"}, rf_write_data, 64'd0);
  endtask

  initial begin
    lane[WB_ALU] = 64'h1111_0000_0000_0001;
    lane[WB_LSU] = 64'h0000_0000_DEAD_BEEF;
    lane[WB_CSR] = 64'h2222_0000_0000_0002;
    wb_data = {lane[2], lane[1], lane[0]};

    tbl[0]  = mk(3'b000, 15'd0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(3'b000, 15'd0, 1, 5, 5, 0, 3'b000, 1, 0, 0, 0, 32'h0);
    tbl[2]  = mk(3'b000, 15'd0, 1, 5, 5, 6, 3'b000, 0, 1, 0, 0, 32'h20);
    tbl[3]  = mk(3'b010, {5'd0, 5'd5, 5'd0}, 0, 0, 5, 0, 3'b010, 0, 1, 0, 5, 32'h20);
    tbl[4]  = mk(3'b100, 15'd0, 1, 0, 5, 0, 3'b100, 1, 0, 0, 0, 32'h0);
    tbl[5]  = mk(3'b111, {5'd12, 5'd11, 5'd10}, 0, 0, 0, 0, 3'b001, 0, 0, 0, 10, 32'h0);
    tbl[6]  = mk(3'b111, {5'd12, 5'd11, 5'd10}, 0, 0, 0, 0, 3'b010, 0, 0, 0, 11, 32'h0);
    tbl[7]  = mk(3'b111, {5'd12, 5'd11, 5'd10}, 0, 0, 0, 0, 3'b100, 0, 0, 0, 12, 32'h0);
    tbl[8]  = mk(3'b111, {5'd12, 5'd11, 5'd10}, 0, 0, 0, 0, 3'b001, 0, 0, 0, 10, 32'h0);
    tbl[9]  = mk(3'b111, {5'd12, 5'd11, 5'd10}, 0, 0, 0, 0, 3'b010, 0, 0, 0, 11, 32'h0);
    tbl[10] = mk(3'b111, {5'd12, 5'd11, 5'd10}, 0, 0, 0, 0, 3'b100, 0, 0, 0, 12, 32'h0);
    tbl[11] = mk(3'b001, {5'd0, 5'd0, 5'd7}, 1, 7, 0, 0, 3'b001, 1, 0, 0, 7, 32'h0);
    tbl[12] = mk(3'b000, 15'd0, 1, 7, 0, 7, 3'b000, 0, 0, 1, 0, 32'h80);
    tbl[13] = mk(3'b010, {5'd0, 5'd7, 5'd0}, 1, 3, 0, 0, 3'b010, 1, 0, 0, 7, 32'h80);
    tbl[14] = mk(3'b000, 15'd0, 1, 9, 3, 9, 3'b000, 1, 1, 0, 0, 32'h08);

    // Reset with live requests: nothing may be granted or accepted.
    rst = 1'b1;
    drive(3'b111, {5'd3, 5'd2, 5'd1}, 1'b1, 5'd4, 5'd1, 5'd2);
    @(posedge clk); #1;
    chk_quiet("init_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < 15; t++) begin
      drive(tbl[t].wbv, tbl[t].rds, tbl[t].iv, tbl[t].ird, tbl[t].rs1, tbl[t].rs2);
      #2;
      chk($sformatf("v%0d wb_ready", t), 64'(wb_ready), 64'(tbl[t].rdy));
      chk($sformatf("v%0d rf_we", t), 64'(rf_we), 64'(|tbl[t].rdy));
      chk($sformatf("v%0d rf_rd", t), 64'(rf_rd), 64'(tbl[t].rd));
      chk($sformatf("v%0d rf_write_data", t), rf_write_data, exp_data(tbl[t].rdy));
      chk($sformatf("v%0d issue_ready", t), 64'(issue_ready), 64'(tbl[t].ir));
      chk($sformatf("v%0d hazard1", t), 64'(hazard1), 64'(tbl[t].h1));
      chk($sformatf("v%0d hazard2", t), 64'(hazard2), 64'(tbl[t].h2));
      chk($sformatf("v%0d busy_vec", t), 64'(busy_vec), 64'(tbl[t].busy));
      @(posedge clk); #1;
    end

    // Pending busy[3], busy[9] and rr_ptr=2 are discarded by a 1-cycle reset.
    chk("pre_rst busy_vec", 64'(busy_vec), 64'h208);
    rst = 1'b1;
    drive(3'b111, {5'd12, 5'd11, 5'd10}, 1'b1, 5'd4, 5'd3, 5'd9);
    #2;
    chk_quiet("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3'b111, {5'd12, 5'd11, 5'd10}, 1'b0, 5'd0, 5'd3, 5'd9);
    #2;
    chk("post_rst busy_vec", 64'(busy_vec), 64'h0);
    chk("post_rst hazard1", 64'(hazard1), 64'd0);
    chk("post_rst wb_ready", 64'(wb_ready), 64'b001);
    chk("post_rst rf_rd", 64'(rf_rd), 64'd10);
    chk("post_rst rf_write_data", rf_write_data, lane[0]);
    @(posedge clk); #1;
    #2;
    chk("post_rst2 wb_ready", 64'(wb_ready), 64'b010);
    drive(3'b000, 15'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    chk("final idle rf_we", 64'(rf_we), 64'd0);
    chk("final idle rf_write_data", rf_write_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
